// File: rtl/serial_sub8.sv
// Bit-serial subtractor: diff = num1 - num2 - bin over WIDTH cycles, LSB first.
// One full-adder cell computes a + ~b with the carry seeded from ~bin.
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             v
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             carry, n1msb, n2msb;

    logic             load, fin, s, c_nx;
    logic [WIDTH-1:0] r_nx;

    assign s    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign r_nx = {s, r_sh[WIDTH-1:1]};
    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            n1msb <= 1'b0;
            n2msb <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            v     <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                a_sh  <= num1;
                b_sh  <= ~num2;
                carry <= ~bin;
                cnt   <= '0;
                n1msb <= num1[WIDTH-1];
                n2msb <= num2[WIDTH-1];
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                r_sh  <= r_nx;
                carry <= c_nx;
                cnt   <= cnt + 1'b1;
                // s is the result MSB on the final bit
                if (fin) begin
                    diff <= r_nx;
                    bout <= ~c_nx;
                    v    <= (n1msb != n2msb) && (s != n1msb);
                end
            end
        end
    end

endmodule
